// File: rtl/wash_temperature_selector.sv
// ---------------------------------------------------------------------------
// wash_temperature_selector
//
// Holds a temperature level index per wash mode and steps it up or down on
// front-panel button edges. The index either wraps or saturates at the mode
// limits. A run lock freezes the selection. The result is a target
// temperature in degC for the heater controller.
//
// Optional feature macro: AUTO_REPEAT_EN
//   defined   : holding exactly one button repeats the step. The first repeat
//               comes HOLD_CYCLES after the edge, then one every REPEAT_CYCLES.
//   undefined : only button edges step. No repeat counter is built.
//
// Ports
//   clk                  in   1       system clock
//   reset                in   1       asynchronous, active-low reset
//   wash_mode            in   MODE_W  selected wash mode (level)
//   increment            in   1       step-up button (debounced level)
//   decrement            in   1       step-down button (debounced level)
//   lock                 in   1       1 = cycle running, selection frozen
//   index                out  IDX_W   registered level index
//   selected_temperature out  TEMP_W  BASE_TEMP + index*STEP_TEMP
//   at_max               out  1       index equals max of the latched mode
//   changed              out  1       one-cycle pulse alongside an index update
// ---------------------------------------------------------------------------
module wash_temperature_selector #(
    parameter int                         NUM_MODES        = 8,
    parameter int                         MODE_W           = 3,
    parameter int                         IDX_W            = 3,
    parameter int                         TEMP_W           = 7,
    parameter int                         BASE_TEMP        = 20,
    parameter int                         STEP_TEMP        = 10,
    parameter logic [NUM_MODES*IDX_W-1:0] MODE_DEFAULT_IDX = 24'h74231A,
    parameter logic [NUM_MODES*IDX_W-1:0] MODE_MAX_IDX     = 24'hDD57FC,
    parameter bit                         WRAP             = 1'b1,
    parameter int                         HOLD_CYCLES      = 16,
    parameter int                         REPEAT_CYCLES    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [MODE_W-1:0] wash_mode,
    input  logic              increment,
    input  logic              decrement,
    input  logic              lock,
    output logic [IDX_W-1:0]  index,
    output logic [TEMP_W-1:0] selected_temperature,
    output logic              at_max,
    output logic              changed
);

    logic [IDX_W-1:0]  index_reg;
    logic [MODE_W-1:0] mode_q_reg;
    logic              loaded_reg;
    logic              changed_reg;
    logic              inc_q_reg;
    logic              dec_q_reg;

    // Per-mode tables unpacked from the parameter vectors. A default above
    // its mode's maximum is clamped once here, not on every reload.
    logic [IDX_W-1:0] dflt_tbl [NUM_MODES];
    logic [IDX_W-1:0] max_tbl  [NUM_MODES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MODES; gi++) begin : g_tbl
            localparam logic [IDX_W-1:0] DEF_IDX = MODE_DEFAULT_IDX[gi*IDX_W +: IDX_W];
            localparam logic [IDX_W-1:0] MAX_IDX = MODE_MAX_IDX[gi*IDX_W +: IDX_W];
            assign dflt_tbl[gi] = (DEF_IDX > MAX_IDX) ? MAX_IDX : DEF_IDX;
            assign max_tbl[gi]  = MAX_IDX;
        end
    endgenerate

    // Mode codes outside the table fall back to index 0 with limit 0.
    logic             mode_ok;
    logic             mode_q_ok;
    logic [IDX_W-1:0] load_idx;
    logic [IDX_W-1:0] cur_max;

    assign mode_ok   = (32'(wash_mode) < NUM_MODES);
    assign mode_q_ok = (32'(mode_q_reg) < NUM_MODES);
    assign load_idx  = mode_ok ? dflt_tbl[wash_mode] : '0;
    assign cur_max   = mode_q_ok ? max_tbl[mode_q_reg] : '0;

    logic inc_edge;
    logic dec_edge;
    logic mode_change;
    logic step_up;
    logic step_dn;
    logic [IDX_W-1:0] next_idx;

    assign inc_edge    = increment & ~inc_q_reg;
    assign dec_edge    = decrement & ~dec_q_reg;
    assign mode_change = (wash_mode != mode_q_reg);

`ifdef AUTO_REPEAT_EN
    // A value of 0 means disarmed. An edge arms the counter at 1, so the
    // counter equals the number of cycles since the edge when it is sampled.
    // After a repeat the counter jumps back so it reaches HOLD_CYCLES again
    // REPEAT_CYCLES later.
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    logic [CNT_W-1:0] rpt_cnt_reg;
    logic             rpt_fire;

    assign rpt_fire = (rpt_cnt_reg == CNT_W'(HOLD_CYCLES)) && (increment ^ decrement);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rpt_cnt_reg <= '0;
        end else if (!loaded_reg || lock || mode_change || !(increment ^ decrement)) begin
            rpt_cnt_reg <= '0;
        end else if (inc_edge || dec_edge) begin
            rpt_cnt_reg <= CNT_W'(1);
        end else if (rpt_cnt_reg == CNT_W'(HOLD_CYCLES)) begin
            rpt_cnt_reg <= CNT_W'(HOLD_CYCLES - REPEAT_CYCLES + 1);
        end else if (rpt_cnt_reg != '0) begin
            rpt_cnt_reg <= rpt_cnt_reg + CNT_W'(1);
        end
    end
`endif

    always_comb begin
        // Simultaneous edges on both buttons cancel out.
        step_up = inc_edge & ~dec_edge;
        step_dn = dec_edge & ~inc_edge;
`ifdef AUTO_REPEAT_EN
        if (rpt_fire) begin
            step_up = increment;
            step_dn = decrement;
        end
`endif
        next_idx = index_reg;
        if (step_up) begin
            if (index_reg >= cur_max) begin
                next_idx = WRAP ? '0 : index_reg;
            end else begin
                next_idx = index_reg + IDX_W'(1);
            end
        end else if (step_dn) begin
            if (index_reg == '0) begin
                next_idx = WRAP ? cur_max : index_reg;
            end else begin
                next_idx = index_reg - IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            index_reg   <= '0;
            mode_q_reg  <= '0;
            loaded_reg  <= 1'b0;
            changed_reg <= 1'b0;
            inc_q_reg   <= 1'b0;
            dec_q_reg   <= 1'b0;
        end else begin
            // Button history follows the inputs even while locked. A button
            // held through unlock therefore has no edge left to act on.
            inc_q_reg   <= increment;
            dec_q_reg   <= decrement;
            changed_reg <= 1'b0;
            if (!loaded_reg || (!lock && mode_change)) begin
                // A reload always pulses changed, even when the value is the same.
                index_reg   <= load_idx;
                mode_q_reg  <= wash_mode;
                loaded_reg  <= 1'b1;
                changed_reg <= 1'b1;
            end else if (!lock && (step_up || step_dn)) begin
                index_reg   <= next_idx;
                changed_reg <= (next_idx != index_reg);
            end
        end
    end

    assign index                = index_reg;
    assign selected_temperature = TEMP_W'(BASE_TEMP) + TEMP_W'(index_reg) * TEMP_W'(STEP_TEMP);
    assign at_max               = (index_reg == cur_max);
    assign changed              = changed_reg;

endmodule

// File: tb/tb_wash_temperature_selector.sv
// ---------------------------------------------------------------------------
// Testbench for wash_temperature_selector.
// Two instances share one stimulus: dut_w wraps, dut_s saturates.
// A bench-side model predicts each cycle. The prediction is queued when the
// inputs are driven. It is popped and compared once the clock edge has acted.
// ---------------------------------------------------------------------------
module tb_wash_temperature_selector;

`ifdef AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    localparam int HOLD = 16;
    localparam int REP  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] wash_mode = 3'd3;
    logic       increment = 1'b0;
    logic       decrement = 1'b0;
    logic       lock = 1'b0;

    logic [2:0] w_index, s_index;
    logic [6:0] w_temp, s_temp;
    logic       w_at_max, s_at_max, w_changed, s_changed;

    always #5 clk = ~clk;

    wash_temperature_selector #(.WRAP(1'b1)) dut_w (
        .clk(clk), .reset(reset), .wash_mode(wash_mode), .increment(increment),
        .decrement(decrement), .lock(lock), .index(w_index),
        .selected_temperature(w_temp), .at_max(w_at_max), .changed(w_changed)
    );

    wash_temperature_selector #(.WRAP(1'b0)) dut_s (
        .clk(clk), .reset(reset), .wash_mode(wash_mode), .increment(increment),
        .decrement(decrement), .lock(lock), .index(s_index),
        .selected_temperature(s_temp), .at_max(s_at_max), .changed(s_changed)
    );

    int def_t [8] = '{2, 3, 4, 1, 2, 0, 5, 3};
    int max_t [8] = '{4, 7, 7, 3, 5, 2, 7, 6};

    typedef struct {
        string name;
        int    w_idx;
        int    s_idx;
        bit    w_chg;
        bit    s_chg;
        int    mode;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Model state
    bit m_loaded, m_inc_q, m_dec_q, m_armed;
    int m_w, m_s, m_mode, m_held;

    logic [11:0] got_w, got_s, want_w, want_s;

    function automatic int clamp_def(int md);
        return (def_t[md] > max_t[md]) ? max_t[md] : def_t[md];
    endfunction

    function automatic int stepf(int idx, int mx, bit up, bit wrap);
        if (up) return (idx >= mx) ? (wrap ? 0 : idx) : idx + 1;
        return (idx == 0) ? (wrap ? mx : 0) : idx - 1;
    endfunction

    // Expected {index, temperature, at_max, changed}.
    function automatic logic [11:0] pack_exp(int idx, int md, bit chg);
        return {3'(idx), 7'(20 + 10 * idx), (idx == max_t[md]), chg};
    endfunction

    task automatic model_reset();
        m_loaded = 0; m_inc_q = 0; m_dec_q = 0; m_armed = 0;
        m_w = 0; m_s = 0; m_mode = 0; m_held = 0;
    endtask

    task automatic push_reset_state(input string nm);
        exp_t e;
        e.name = nm; e.w_idx = 0; e.s_idx = 0; e.w_chg = 0; e.s_chg = 0; e.mode = 0;
        sb.push_back(e);
    endtask

    // Drive one cycle of stimulus, predict its effect, queue the prediction,
    // and advance to just after the clock edge.
    task automatic apply(input string nm, input bit i, input bit d, input bit lk, input int md);
        exp_t e;
        bit ie, de, up, dn;
        int nw, ns;
        increment = i; decrement = d; lock = lk; wash_mode = 3'(md);
        ie = i && !m_inc_q;
        de = d && !m_dec_q;
        up = 0; dn = 0;
        e.w_chg = 0; e.s_chg = 0;
        if (!m_loaded || (!lk && md != m_mode)) begin
            m_w = clamp_def(md); m_s = m_w; m_mode = md; m_loaded = 1;
            e.w_chg = 1; e.s_chg = 1; m_armed = 0;
        end else if (lk) begin
            m_armed = 0;
        end else begin
            if (ie && de) begin
                m_armed = 0;
            end else if (ie || de) begin
                up = ie; dn = de; m_armed = 1; m_held = 0;
            end else if (m_armed && (i ^ d)) begin
                m_held++;
                if (AUTO && m_held >= HOLD && ((m_held - HOLD) % REP) == 0) begin
                    up = i; dn = d;
                end
            end else begin
                m_armed = 0;
            end
            if (up || dn) begin
                nw = stepf(m_w, max_t[m_mode], up, 1'b1);
                ns = stepf(m_s, max_t[m_mode], up, 1'b0);
                e.w_chg = (nw != m_w); e.s_chg = (ns != m_s);
                m_w = nw; m_s = ns;
            end
        end
        m_inc_q = i; m_dec_q = d;
        e.name = nm; e.w_idx = m_w; e.s_idx = m_s; e.mode = m_mode;
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        exp_t e;
        model_reset();
        reset = 0; wash_mode = 3'd3; increment = 0; decrement = 0; lock = 0;
        for (int k = 0; k < 3; k++) begin
            push_reset_state("reset_hold");
            @(posedge clk); #1;
            e = sb.pop_front();
            got_w = {w_index, w_temp, w_at_max, w_changed};
            got_s = {s_index, s_temp, s_at_max, s_changed};
            want_w = pack_exp(e.w_idx, e.mode, e.w_chg);
            want_s = pack_exp(e.s_idx, e.mode, e.s_chg);
            checks += 2;
            if (got_w !== want_w) begin errors++; $display("FAIL %s wrap: got idx/temp/max/chg=%0d/%0d/%0b/%0b want %0d/%0d/%0b/%0b", e.name, got_w[11:9], got_w[8:2], got_w[1], got_w[0], want_w[11:9], want_w[8:2], want_w[1], want_w[0]); end
            if (got_s !== want_s) begin errors++; $display("FAIL %s sat: got idx/temp/max/chg=%0d/%0d/%0b/%0b want %0d/%0d/%0b/%0b", e.name, got_s[11:9], got_s[8:2], got_s[1], got_s[0], want_s[11:9], want_s[8:2], want_s[1], want_s[0]); end
            $display("reset cycle %0d: idx=%0d temp=%0d changed=%0b", k, w_index, w_temp, w_changed);
        end
        reset = 1;
        for (int k = 0; k < 2; k++) begin
            apply(k == 0 ? "first_load" : "after_load", 1'b0, 1'b0, 1'b0, 3);
            e = sb.pop_front();
            got_w = {w_index, w_temp, w_at_max, w_changed};
            got_s = {s_index, s_temp, s_at_max, s_changed};
            want_w = pack_exp(e.w_idx, e.mode, e.w_chg);
            want_s = pack_exp(e.s_idx, e.mode, e.s_chg);
            checks += 2;
            if (got_w !== want_w) begin errors++; $display("FAIL %s wrap: got idx/temp/max/chg=%0d/%0d/%0b/%0b want %0d/%0d/%0b/%0b", e.name, got_w[11:9], got_w[8:2], got_w[1], got_w[0], want_w[11:9], want_w[8:2], want_w[1], want_w[0]); end
            if (got_s !== want_s) begin errors++; $display("FAIL %s sat: got idx/temp/max/chg=%0d/%0d/%0b/%0b want %0d/%0d/%0b/%0b", e.name, got_s[11:9], got_s[8:2], got_s[1], got_s[0], want_s[11:9], want_s[8:2], want_s[1], want_s[0]); end
            $display("%s: idx=%0d temp=%0d changed=%0b", e.name, w_index, w_temp, w_changed);
        end
    endtask

    task automatic test_inc_wrap();
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            apply("inc_pulse", (k % 2) == 0, 1'b0, 1'b0, 3);
            e = sb.pop_front();
            got_w = {w_index, w_temp, w_at_max, w_changed};
            got_s = {s_index, s_temp, s_at_max, s_changed};
            want_w = pack_exp(e.w_idx, e.mode, e.w_chg);
            want_s = pack_exp(e.s_idx, e.mode, e.s_chg);
            checks += 2;
            if (got_w !== want_w) begin errors++; $display("FAIL %s wrap: got idx/temp/max/chg=%0d/%0d/%0b/%0b want %0d/%0d/%0b/%0b", e.name, got_w[11:9], got_w[8:2], got_w[1], got_w[0], want_w[11:9], want_w[8:2], want_w[1], want_w[0]); end
            if (got_s !== want_s) begin errors++; $display("FAIL %s sat: got idx/temp/max/chg=%0d/%0d/%0b/%0b want %0d/%0d/%0b/%0b", e.name, got_s[11:9], got_s[8:2], got_s[1], got_s[0], want_s[11:9], want_s[8:2], want_s[1], want_s[0]); end
            $display("inc step %0d: wrap idx=%0d temp=%0d at_max=%0b | sat idx=%0d changed=%0b", k, w_index, w_temp, w_at_max, s_index, s_changed);
        end
    endtask

    task automatic test_dec_and_both();
        exp_t e;
        bit i_t [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
        bit d_t [8] = '{0, 0, 1, 0, 1, 0, 1, 0};
        int m_t [8] = '{0, 3, 3, 3, 3, 3, 3, 3};
        for (int k = 0; k < 8; k++) begin
            apply(k < 2 ? "mode_reload" : (k < 6 ? "dec_pulse" : "inc_dec_same"), i_t[k], d_t[k], 1'b0, m_t[k]);
            e = sb.pop_front();
            got_w = {w_index, w_temp, w_at_max, w_changed};
            got_s = {s_index, s_temp, s_at_max, s_changed};
            want_w = pack_exp(e.w_idx, e.mode, e.w_chg);
            want_s = pack_exp(e.s_idx, e.mode, e.s_chg);
            checks += 2;
            if (got_w !== want_w) begin errors++; $display("FAIL %s wrap: got idx/temp/max/chg=%0d/%0d/%0b/%0b want %0d/%0d/%0b/%0b", e.name, got_w[11:9], got_w[8:2], got_w[1], got_w[0], want_w[11:9], want_w[8:2], want_w[1], want_w[0]); end
            if (got_s !== want_s) begin errors++; $display("FAIL %s sat: got idx/temp/max/chg=%0d/%0d/%0b/%0b want %0d/%0d/%0b/%0b", e.name, got_s[11:9], got_s[8:2], got_s[1], got_s[0], want_s[11:9], want_s[8:2], want_s[1], want_s[0]); end
            $display("%s %0d: wrap idx=%0d changed=%0b | sat idx=%0d changed=%0b", e.name, k, w_index, w_changed, s_index, s_changed);
        end
    endtask

    task automatic test_lock();
        exp_t e;
        bit i_t [9] = '{1, 0, 1, 0, 1, 1, 1, 1, 0};
        bit l_t [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
        int m_t [9] = '{3, 3, 3, 3, 7, 7, 7, 7, 7};
        for (int k = 0; k < 9; k++) begin
            apply(l_t[k] ? "locked" : "unlocked", i_t[k], 1'b0, l_t[k], m_t[k]);
            e = sb.pop_front();
            got_w = {w_index, w_temp, w_at_max, w_changed};
            got_s = {s_index, s_temp, s_at_max, s_changed};
            want_w = pack_exp(e.w_idx, e.mode, e.w_chg);
            want_s = pack_exp(e.s_idx, e.mode, e.s_chg);
            checks += 2;
            if (got_w !== want_w) begin errors++; $display("FAIL %s wrap: got idx/temp/max/chg=%0d/%0d/%0b/%0b want %0d/%0d/%0b/%0b", e.name, got_w[11:9], got_w[8:2], got_w[1], got_w[0], want_w[11:9], want_w[8:2], want_w[1], want_w[0]); end
            if (got_s !== want_s) begin errors++; $display("FAIL %s sat: got idx/temp/max/chg=%0d/%0d/%0b/%0b want %0d/%0d/%0b/%0b", e.name, got_s[11:9], got_s[8:2], got_s[1], got_s[0], want_s[11:9], want_s[8:2], want_s[1], want_s[0]); end
            $display("%s %0d: idx=%0d temp=%0d changed=%0b", e.name, k, w_index, w_temp, w_changed);
        end
    endtask

    task automatic test_reset_mid_hold();
        exp_t e;
        apply("pre_hold", 1'b0, 1'b0, 1'b0, 7);
        void'(sb.pop_front());
        apply("hold_edge", 1'b1, 1'b0, 1'b0, 7);
        void'(sb.pop_front());
        // Reset lands mid-cycle and must clear the index without waiting for a clock.
        #2 reset = 0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            push_reset_state("reset_mid_hold");
            if (k > 0) begin @(posedge clk); #1; end
            e = sb.pop_front();
            got_w = {w_index, w_temp, w_at_max, w_changed};
            got_s = {s_index, s_temp, s_at_max, s_changed};
            want_w = pack_exp(e.w_idx, e.mode, e.w_chg);
            want_s = pack_exp(e.s_idx, e.mode, e.s_chg);
            checks += 2;
            if (got_w !== want_w) begin errors++; $display("FAIL %s wrap: got idx/temp/max/chg=%0d/%0d/%0b/%0b want %0d/%0d/%0b/%0b", e.name, got_w[11:9], got_w[8:2], got_w[1], got_w[0], want_w[11:9], want_w[8:2], want_w[1], want_w[0]); end
            if (got_s !== want_s) begin errors++; $display("FAIL %s sat: got idx/temp/max/chg=%0d/%0d/%0b/%0b want %0d/%0d/%0b/%0b", e.name, got_s[11:9], got_s[8:2], got_s[1], got_s[0], want_s[11:9], want_s[8:2], want_s[1], want_s[0]); end
            $display("reset mid hold %0d: idx=%0d changed=%0b", k, w_index, w_changed);
        end
        @(posedge clk); #1;
        reset = 1;
        for (int k = 0; k < 4; k++) begin
            apply(k == 0 ? "reload_held" : "held_no_step", k < 3, 1'b0, 1'b0, 7);
            e = sb.pop_front();
            got_w = {w_index, w_temp, w_at_max, w_changed};
            got_s = {s_index, s_temp, s_at_max, s_changed};
            want_w = pack_exp(e.w_idx, e.mode, e.w_chg);
            want_s = pack_exp(e.s_idx, e.mode, e.s_chg);
            checks += 2;
            if (got_w !== want_w) begin errors++; $display("FAIL %s wrap: got idx/temp/max/chg=%0d/%0d/%0b/%0b want %0d/%0d/%0b/%0b", e.name, got_w[11:9], got_w[8:2], got_w[1], got_w[0], want_w[11:9], want_w[8:2], want_w[1], want_w[0]); end
            if (got_s !== want_s) begin errors++; $display("FAIL %s sat: got idx/temp/max/chg=%0d/%0d/%0b/%0b want %0d/%0d/%0b/%0b", e.name, got_s[11:9], got_s[8:2], got_s[1], got_s[0], want_s[11:9], want_s[8:2], want_s[1], want_s[0]); end
            $display("%s %0d: idx=%0d changed=%0b", e.name, k, w_index, w_changed);
        end
    endtask

    task automatic test_auto_repeat();
        exp_t e;
        for (int k = 0; k < 27; k++) begin
            apply(k == 0 ? "mode1_load" : (k == 26 ? "release" : "inc_held"), k >= 1 && k <= 25, 1'b0, 1'b0, 1);
            e = sb.pop_front();
            got_w = {w_index, w_temp, w_at_max, w_changed};
            got_s = {s_index, s_temp, s_at_max, s_changed};
            want_w = pack_exp(e.w_idx, e.mode, e.w_chg);
            want_s = pack_exp(e.s_idx, e.mode, e.s_chg);
            checks += 2;
            if (got_w !== want_w) begin errors++; $display("FAIL %s wrap: got idx/temp/max/chg=%0d/%0d/%0b/%0b want %0d/%0d/%0b/%0b", e.name, got_w[11:9], got_w[8:2], got_w[1], got_w[0], want_w[11:9], want_w[8:2], want_w[1], want_w[0]); end
            if (got_s !== want_s) begin errors++; $display("FAIL %s sat: got idx/temp/max/chg=%0d/%0d/%0b/%0b want %0d/%0d/%0b/%0b", e.name, got_s[11:9], got_s[8:2], got_s[1], got_s[0], want_s[11:9], want_s[8:2], want_s[1], want_s[0]); end
            $display("%s %0d: idx=%0d changed=%0b", e.name, k, w_index, w_changed);
        end
        // Final level after a 25-cycle hold, taken straight from the expected sequence.
        checks++;
        if (w_index !== (AUTO ? 3'd7 : 3'd4)) begin
            errors++;
            $display("FAIL auto_repeat_final: got idx=%0d want %0d", w_index, AUTO ? 7 : 4);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_inc_wrap();
        test_dec_and_both();
        test_lock();
        test_reset_mid_hold();
        test_auto_repeat();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        checks++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
